// File: rtl/spi_byte_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) master: one full-duplex WIDTH-bit transfer per start pulse.
// Optional macro SPI_LSB_FIRST_EN: send tx_data[0] first and land the first received bit in rx_data[0].
module spi_byte_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a one-cycle request taken only while idle (busy=0); it is
  // never queued. done pulses for exactly one cycle per completed transfer, in the
  // same cycle rx_data takes the new word and busy drops.

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, XFER = 2'd2, HOLD = 2'd3} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             sclk_q, sclk_d;
  logic             done_q, done_d;
  logic             tick;
  logic             all_bits;

`ifdef SPI_LSB_FIRST_EN
  assign mosi = tx_sr_q[0];

  function automatic logic [WIDTH-1:0] tx_shift(input logic [WIDTH-1:0] v);
    return {1'b0, v[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] rx_shift(input logic [WIDTH-1:0] v, input logic b);
    return {b, v[WIDTH-1:1]};
  endfunction
`else
  assign mosi = tx_sr_q[WIDTH-1];

  function automatic logic [WIDTH-1:0] tx_shift(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [WIDTH-1:0] rx_shift(input logic [WIDTH-1:0] v, input logic b);
    return {v[WIDTH-2:0], b};
  endfunction
`endif

  assign tick     = (div_cnt_q == CNT_MAX);
  // After the last falling edge, the low half-period still belongs to XFER.
  assign all_bits = (bit_cnt_q == BIT_ALL);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (tick) state_d = XFER;
      XFER:    if (tick && !sclk_q && all_bits) state_d = HOLD;
      HOLD:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    done_d    = 1'b0;
    if (state_q != IDLE) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (start) begin
          tx_sr_d   = tx_data;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          sclk_d    = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_sr_d = rx_shift(rx_sr_q, miso);
        end
      end
      XFER: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q != BIT_LAST) tx_sr_d = tx_shift(tx_sr_q);
          end else if (!all_bits) begin
            sclk_d  = 1'b1;
            rx_sr_d = rx_shift(rx_sr_q, miso);
          end
        end
      end
      HOLD: begin
        if (tick) begin
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          tx_sr_d   = '0;
        end
      end
      default: begin
        sclk_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign cs_n      = (state_q == IDLE);
  assign sclk      = sclk_q;
  assign done      = done_q;
  assign rx_data   = rx_data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: default instance (CLK_DIV=4) plus a CLK_DIV=1 instance.
// Build with +define+SPI_LSB_FIRST_EN to add the LSB-first scenario.
module tb_spi_byte_master;

  logic       clock = 1'b0;
  logic       reset;
  int         n_vec = 0;
  int         n_err = 0;

  logic       start, miso, busy, done, sclk, mosi, cs_n;
  logic [7:0] tx_data, rx_data;
  logic [1:0] state_dbg;

  logic       start_1, miso_1, busy_1, done_1, sclk_1, mosi_1, cs_n_1;
  logic [7:0] tx_data_1, rx_data_1;
  logic [1:0] state_dbg_1;

  int         s_idx = 0;
  int         rise_cnt = 0;
  int         cs_low_cnt = 0;
  int         done_cnt = 0;
  logic       sclk_prev = 1'b0;
  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] s_word = 8'h00;

  always #5 clock = ~clock;

  spi_byte_master #(.WIDTH(8), .CLK_DIV(4)) dut (
    .clock(clock), .reset(reset), .start(start), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n),
    .state_dbg(state_dbg)
  );

  spi_byte_master #(.WIDTH(8), .CLK_DIV(1)) dut_1 (
    .clock(clock), .reset(reset), .start(start_1), .tx_data(tx_data_1), .rx_data(rx_data_1),
    .busy(busy_1), .done(done_1), .sclk(sclk_1), .mosi(mosi_1), .miso(miso_1), .cs_n(cs_n_1),
    .state_dbg(state_dbg_1)
  );

  // Mode-0 slave for the default instance: shifts s_word out MSB-first, changing after sclk falls.
  always @(negedge clock) begin
    if (cs_n === 1'b1) s_idx = 0;
    else if (sclk_prev === 1'b1 && sclk === 1'b0) s_idx = s_idx + 1;
    if (cs_n === 1'b0 && sclk_prev === 1'b0 && sclk === 1'b1) begin
      mosi_cap = {mosi_cap[6:0], mosi};
      rise_cnt = rise_cnt + 1;
    end
    if (cs_n === 1'b0) cs_low_cnt = cs_low_cnt + 1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
    sclk_prev = sclk;
    miso = (s_idx < 8) ? s_word[7 - s_idx] : 1'b0;
  end

  // Order in which a word appears on the wire / in rx_data for this build.
  function automatic logic [7:0] ord(input logic [7:0] v);
    logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = v[7 - i];
`else
    r = v;
`endif
    return r;
  endfunction

  task automatic start_xfer(input logic [7:0] d);
    @(negedge clock);
    start   = 1'b1;
    tx_data = d;
    @(negedge clock);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_vec++; if (cs_n !== 1'b1) begin n_err++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
    n_vec++; if (sclk !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    n_vec++; if (mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    n_vec++; if (cs_n_1 !== 1'b1 || sclk_1 !== 1'b0 || busy_1 !== 1'b0 || rx_data_1 !== 8'h00) begin
      n_err++; $display("FAIL reset_dut1: cs_n=%b sclk=%b busy=%b rx=%h want 1 0 0 00", cs_n_1, sclk_1, busy_1, rx_data_1);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic;
    int n, r0, c0, d0;
    s_word = 8'h3C;
    r0 = rise_cnt; c0 = cs_low_cnt; d0 = done_cnt;
    start_xfer(8'hA5);
    n_vec++; if (cs_n !== 1'b0) begin n_err++; $display("FAIL basic_cs_low: got %b want 0", cs_n); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
    n_vec++; if (mosi !== 1'b1) begin n_err++; $display("FAIL basic_first_bit: got %b want 1", mosi); end
    wait_done(1, n);
    n_vec++; if (n !== 73) begin n_err++; $display("FAIL basic_latency: got %0d want 73", n); end
    n_vec++; if (rx_data !== ord(8'h3C)) begin n_err++; $display("FAIL basic_rx: got %h want %h", rx_data, ord(8'h3C)); end
    n_vec++; if (busy !== 1'b0 || cs_n !== 1'b1 || mosi !== 1'b0) begin
      n_err++; $display("FAIL basic_done_bus: busy=%b cs_n=%b mosi=%b want 0 1 0", busy, cs_n, mosi);
    end
    @(negedge clock);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %b want 0", done); end
    n_vec++; if (mosi_cap !== ord(8'hA5)) begin n_err++; $display("FAIL basic_mosi: got %h want %h", mosi_cap, ord(8'hA5)); end
    n_vec++; if (rise_cnt - r0 !== 8) begin n_err++; $display("FAIL basic_rises: got %0d want 8", rise_cnt - r0); end
    n_vec++; if (cs_low_cnt - c0 !== 72) begin n_err++; $display("FAIL basic_cs_len: got %0d want 72", cs_low_cnt - c0); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_start_while_busy;
    int n, d0;
    s_word = 8'h3C;
    d0 = done_cnt;
    start_xfer(8'hA5);
    repeat (9) @(negedge clock);
    start   = 1'b1;
    tx_data = 8'hFF;
    @(negedge clock);
    start   = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_mid: got %b want 1", busy); end
    wait_done(11, n);
    n_vec++; if (n !== 73) begin n_err++; $display("FAIL busy_latency: got %0d want 73", n); end
    n_vec++; if (rx_data !== ord(8'h3C)) begin n_err++; $display("FAIL busy_rx: got %h want %h", rx_data, ord(8'h3C)); end
    @(negedge clock);
    n_vec++; if (mosi_cap !== ord(8'hA5)) begin n_err++; $display("FAIL busy_mosi: got %h want %h", mosi_cap, ord(8'hA5)); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt - d0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_not_queued: got %b want 0", busy); end
  endtask

  task automatic test_mid_reset;
    int n, d0;
    s_word = 8'h3C;
    d0 = done_cnt;
    start_xfer(8'hA5);
    repeat (29) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_vec++; if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_bus: cs_n=%b sclk=%b busy=%b want 1 0 0", cs_n, sclk, busy);
    end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rst_rx: got %h want 00", rx_data); end
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
    repeat (100) @(negedge clock);
    n_vec++; if (done_cnt !== d0) begin n_err++; $display("FAIL rst_no_done: got %0d want %0d", done_cnt, d0); end
    start_xfer(8'hA5);
    wait_done(1, n);
    n_vec++; if (n !== 73) begin n_err++; $display("FAIL rst_fresh_latency: got %0d want 73", n); end
    n_vec++; if (rx_data !== ord(8'h3C)) begin n_err++; $display("FAIL rst_fresh_rx: got %h want %h", rx_data, ord(8'h3C)); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    int n, d0;
    s_word = 8'hC5;
    d0 = done_cnt;
    start_xfer(8'h12);
    wait_done(1, n);
    n_vec++; if (rx_data !== ord(8'hC5)) begin n_err++; $display("FAIL b2b_rx1: got %h want %h", rx_data, ord(8'hC5)); end
    n_vec++; if (mosi_cap !== ord(8'h12)) begin n_err++; $display("FAIL b2b_mosi1: got %h want %h", mosi_cap, ord(8'h12)); end
    n_vec++; if (cs_n !== 1'b1) begin n_err++; $display("FAIL b2b_gap: got %b want 1", cs_n); end
    start   = 1'b1;
    tx_data = 8'h34;
    s_word  = 8'h2B;
    @(negedge clock);
    start   = 1'b0;
    n_vec++; if (cs_n !== 1'b0) begin n_err++; $display("FAIL b2b_gap_len: got %b want 0", cs_n); end
    n_vec++; if (rx_data !== ord(8'hC5)) begin n_err++; $display("FAIL b2b_rx_stable: got %h want %h", rx_data, ord(8'hC5)); end
    wait_done(1, n);
    n_vec++; if (n !== 73) begin n_err++; $display("FAIL b2b_latency2: got %0d want 73", n); end
    n_vec++; if (rx_data !== ord(8'h2B)) begin n_err++; $display("FAIL b2b_rx2: got %h want %h", rx_data, ord(8'h2B)); end
    n_vec++; if (mosi_cap !== ord(8'h34)) begin n_err++; $display("FAIL b2b_mosi2: got %h want %h", mosi_cap, ord(8'h34)); end
    @(negedge clock);
    n_vec++; if (done_cnt - d0 !== 2) begin n_err++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_fast_clock;
    int n, idx, cs_low, toggles, rises;
    logic       prev;
    logic [7:0] w, cap;
    w = 8'hC3; idx = 0; cs_low = 0; toggles = 0; rises = 0; prev = 1'b0; cap = 8'h00;
    miso_1 = w[7];
    @(negedge clock);
    start_1   = 1'b1;
    tx_data_1 = 8'h81;
    @(negedge clock);
    start_1   = 1'b0;
    n = 1;
    while (done_1 !== 1'b1 && n < 100) begin
      if (cs_n_1 === 1'b0) cs_low++;
      if (sclk_1 !== prev) toggles++;
      if (prev === 1'b0 && sclk_1 === 1'b1) begin rises++; cap = {cap[6:0], mosi_1}; end
      if (prev === 1'b1 && sclk_1 === 1'b0) idx++;
      miso_1 = (idx < 8) ? w[7 - idx] : 1'b0;
      prev = sclk_1;
      @(negedge clock);
      n++;
    end
    n_vec++; if (n !== 19) begin n_err++; $display("FAIL fast_latency: got %0d want 19", n); end
    n_vec++; if (cs_low !== 18) begin n_err++; $display("FAIL fast_cs_len: got %0d want 18", cs_low); end
    n_vec++; if (toggles !== 16) begin n_err++; $display("FAIL fast_toggles: got %0d want 16", toggles); end
    n_vec++; if (rises !== 8) begin n_err++; $display("FAIL fast_rises: got %0d want 8", rises); end
    n_vec++; if (cap !== ord(8'h81)) begin n_err++; $display("FAIL fast_mosi: got %h want %h", cap, ord(8'h81)); end
    n_vec++; if (rx_data_1 !== ord(8'hC3)) begin n_err++; $display("FAIL fast_rx: got %h want %h", rx_data_1, ord(8'hC3)); end
    @(negedge clock);
  endtask

`ifdef SPI_LSB_FIRST_EN
  task automatic test_lsb_first;
    int n;
    s_word = 8'h80;
    start_xfer(8'h01);
    n_vec++; if (mosi !== 1'b1) begin n_err++; $display("FAIL lsb_first_bit: got %b want 1", mosi); end
    wait_done(1, n);
    n_vec++; if (n !== 73) begin n_err++; $display("FAIL lsb_latency: got %0d want 73", n); end
    n_vec++; if (rx_data !== 8'h01) begin n_err++; $display("FAIL lsb_rx: got %h want 01", rx_data); end
    n_vec++; if (mosi_cap !== 8'h80) begin n_err++; $display("FAIL lsb_mosi_seq: got %h want 80", mosi_cap); end
    @(negedge clock);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; tx_data = 8'h00;
    start_1 = 1'b0; tx_data_1 = 8'h00; miso_1 = 1'b0;
    test_reset;
    test_basic;
    test_start_while_busy;
    test_mid_reset;
    test_back_to_back;
    test_fast_clock;
`ifdef SPI_LSB_FIRST_EN
    test_lsb_first;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_byte_master.md
Name: spi_byte_master

Overview:
SPI mode-0 master that performs one full-duplex WIDTH-bit transfer per start pulse. It sits directly downstream of the power-up start timer: the timer's one-cycle start pulse launches the first transfer. Later pulses come from the command sequencer. It drives sclk/mosi/cs_n to the external device and returns the received word with a one-cycle done strobe.

Parameters:
WIDTH, 8, bits per transfer (>=2)
CLK_DIV, 4, system clocks per sclk half-period (>=1)

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high
start  input  1  one-cycle launch pulse; honoured only when idle
tx_data  input  WIDTH  word to transmit; sampled on the accepted start cycle
rx_data  output  WIDTH  last received word; updated on the done cycle
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse at transfer completion
sclk  output  1  SPI clock, idles low (CPOL=0)
mosi  output  1  serial data out
miso  input  1  serial data in
cs_n  output  1  chip select, active low

Behaviour:
- Reset values: cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, state=IDLE, counters=0. Reset wins over every other event, including mid-transfer. The bus returns to idle on the next edge, and no done pulse is produced.
- Clock-divider counter runs 0..CLK_DIV-1 in every non-IDLE state. A "tick" is the cycle the counter equals CLK_DIV-1. The counter clears on each state change.
- IDLE: busy=0, cs_n=1, sclk=0.
  - On start=1: latch tx_data into the tx shift register, clear the rx shift register and the bit counter, and go to SETUP.
  - Next cycle: cs_n=0, busy=1, mosi=first bit (MSB by default).
- SETUP: lasts CLK_DIV cycles. On tick, go to XFER and drive sclk=1 (first rising edge).
- XFER: sclk toggles on every tick.
  - Rising edge (sclk 0->1 registered): shift miso into the rx shift register. miso is sampled at the same clock edge that sets sclk=1.
  - Falling edge (sclk 1->0): increment the bit counter. If bits remain, shift and drive the next tx bit on mosi.
  - After the WIDTH-th falling edge, go to HOLD. sclk=0 and mosi holds the last bit.
- HOLD: lasts CLK_DIV cycles. On tick:
  - cs_n=1, done=1, busy=0, rx_data<=rx shift register, mosi=0.
  - Return to IDLE.
- Timing:
  - cs_n is low for exactly CLK_DIV*(2*WIDTH+2) cycles; for the defaults that is 72.
  - done occurs CLK_DIV*(2*WIDTH+2)+1 cycles after the start cycle.
  - sclk produces exactly WIDTH rising edges per transfer.
- start while busy=1: ignored, with no effect on the current transfer. It is not queued.
- start on the done cycle: accepted because the state is IDLE, so cs_n is high for exactly one cycle between transfers.
- tx_data changes after acceptance have no effect. rx_data is stable between done pulses.

Optional Feature:
SPI_LSB_FIRST_EN
- Defined: transmit tx_data[0] first, and shift received bits in from the MSB side so the first received bit lands in rx_data[0].
- Undefined (default): MSB first on both mosi and rx_data.
- Timing is identical in both configurations.

Test Plan:
1. Defaults, tx_data=0xA5 with a mode-0 slave model returning 0x3C -> mosi bits sampled at sclk rises are 1,0,1,0,0,1,0,1; rx_data=0x3C; done single-cycle; cs_n low 72 cycles; 8 sclk rises.
2. Pulse start again 10 cycles into the transfer with tx_data=0xFF -> ignored; mosi still carries 0xA5; exactly one done.
3. Assert reset at cycle 30 of a transfer -> next cycle cs_n=1, sclk=0, busy=0, rx_data=0, no done. A fresh start then completes normally with 0x3C.
4. Back-to-back transfers 0x12 then 0x34 (second start on the done cycle) -> cs_n high for 1 cycle; slave sees both words; rx_data updates twice.
5. CLK_DIV=1, WIDTH=8, tx_data=0x81 -> cs_n low 18 cycles; sclk toggles every cycle; rx_data matches the slave's 0xC3.
6. With SPI_LSB_FIRST_EN defined, tx_data=0x01 and slave sending bits 1,0,0,0,0,0,0,0 -> mosi first bit=1; rx_data=0x01.
